// File: rtl/sr04_pkg.sv
// sr04_pkg: FSM state encoding and default timing constants for the SR04 UART transmitter.
package sr04_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam int DEF_CLK_HZ = 100_000_000;
   localparam int DEF_BAUD   = 9600;
   function automatic int timer_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction
endpackage

// File: rtl/ascii_fifo.sv
// ascii_fifo: byte FIFO with extra-MSB pointers; a push while full succeeds only alongside a pop.
module ascii_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic        wr_en, rd_en;
   always_comb begin
      empty = wr_q == rd_q;
      full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      rd_en = pop && !empty;
      wr_en = push && (!full || rd_en);
      dout  = mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + (AW+1)'(1);
         if (rd_en) rd_q <= rd_q + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/sr04_uart_tx.sv
// sr04_uart_tx: buffers ASCII strobes in a FIFO and shifts them out as 8N1 frames.
module sr04_uart_tx
   import sr04_pkg::*;
#(
   parameter int CLK_HZ = DEF_CLK_HZ,
   parameter int BAUD   = DEF_BAUD,
   parameter int DEPTH  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go_ascii,
   input  logic [7:0] ascii,
   output logic       tx,
   output logic       tx_busy,
   output logic       fifo_full,
   output logic       overflow
);
   localparam int BIT_DIV = CLK_HZ / BAUD;
   localparam int TW = timer_width(BIT_DIV);
   localparam logic [TW-1:0] LAST = TW'(BIT_DIV - 1);
   state_t        state_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q, dout;
   logic          tx_q, busy_q, overflow_q, full, empty, pop, bit_end;
   ascii_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (go_ascii),
      .pop   (pop),
      .din   (ascii),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      pop     = (state_q == IDLE) && !empty;
      bit_end = timer_q == LAST;
      timer_d = bit_end ? '0 : timer_q + TW'(1);
   end
   always_ff @(posedge clk) begin
      overflow_q <= rst ? 1'b0 : overflow_q | (go_ascii & full & ~pop);
   end
   // tx and tx_busy are updated on the same edge as the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (!empty) begin
               state_q <= START;
               shift_q <= dout;
               timer_q <= '0;
               bit_q   <= '0;
               tx_q    <= 1'b0;
               busy_q  <= 1'b1;
            end
            START: begin
               timer_q <= timer_d;
               if (bit_end) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
               end
            end
            DATA: begin
               timer_q <= timer_d;
               if (bit_end) begin
                  bit_q   <= bit_q + 3'd1;
                  shift_q <= shift_q >> 1;
                  tx_q    <= (bit_q == 3'd7) ? 1'b1 : shift_q[1];
                  if (bit_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               timer_q <= timer_d;
               if (bit_end) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign tx        = tx_q;
   assign tx_busy   = busy_q;
   assign fifo_full = full;
   assign overflow  = overflow_q;
endmodule
